// File: rtl/ebi_fifo_pkg.sv
// Shared types and helpers for the EBI FIFO write-side arbiter.
package ebi_fifo_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Default packet length limit before a grant is forcibly released
  localparam int MAX_BEATS_DEF = 16;

  // Width of an encoded requester index (never narrower than one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ebi_fifo_wr_arb_if.sv
// Requester/FIFO write-port bundle for ebi_fifo_wr_arb.
// Optional performance counters appear when EBI_WARB_PERF_CNT_EN is defined.
// master: the arbiter. slave: requesters plus the FIFO write-pointer block.
interface ebi_fifo_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  import ebi_fifo_pkg::*;

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wfull;
  logic               awfull;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic               grant_vld;
  logic [IW-1:0]      grant_id;
  logic               pkt_err;
`ifdef EBI_WARB_PERF_CNT_EN
  logic [NREQ*32-1:0] beat_cnt;
  logic [31:0]        stall_cnt;

  modport master (
    input  req_valid, req_last, req_data, wfull, awfull,
    output req_ready, winc, wdata, grant_vld, grant_id, pkt_err,
    output beat_cnt, stall_cnt
  );
  modport slave (
    output req_valid, req_last, req_data, wfull, awfull,
    input  req_ready, winc, wdata, grant_vld, grant_id, pkt_err,
    input  beat_cnt, stall_cnt
  );
`else
  modport master (
    input  req_valid, req_last, req_data, wfull, awfull,
    output req_ready, winc, wdata, grant_vld, grant_id, pkt_err
  );
  modport slave (
    output req_valid, req_last, req_data, wfull, awfull,
    input  req_ready, winc, wdata, grant_vld, grant_id, pkt_err
  );
`endif

endinterface

// File: rtl/ebi_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// the last-grant pointer, wrapping modulo NREQ.
module ebi_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt_oh,
  output logic [IW-1:0]   o_gnt_idx
);

  // Scan NREQ slots starting one past the previous winner
  always_comb begin
    int   w_idx;
    logic w_found;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = int'(i_last) + off;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_gnt_oh[w_idx]  = 1'b1;
        o_gnt_idx        = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ebi_fifo_wr_arb.sv
// Write-side scheduler for the EBI async FIFO: packet-atomic round-robin
// sharing of the FIFO write port, throttled by the registered wfull/awfull.
// Optional per-requester beat and stall counters: EBI_WARB_PERF_CNT_EN.
//
//   state | meaning
//   IDLE  | no grant held; issue one when a request is pending and FIFO has room
//   XFER  | grant held; beats of grant_id flow straight to the FIFO until
//         | last beat or MAX_BEATS, then one bubble cycle in IDLE
module ebi_fifo_wr_arb
  import ebi_fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input logic              wclk,
  input logic              wrst,
  ebi_fifo_wr_arb_if.master bus
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);
  localparam logic [IW-1:0] RR_RST   = IW'(NREQ - 1);

  arb_state_e      r_state;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_gid;
  logic            r_gvld;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_pick_oh;
  logic [IW-1:0]   w_pick_idx;
  logic            w_xfer;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [DW-1:0]   w_sel_data;
  logic            w_accept;
  logic            w_release;

  ebi_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req     (bus.req_valid),
    .i_last    (r_rr),
    .o_gnt_oh  (w_pick_oh),
    .o_gnt_idx (w_pick_idx)
  );

  // Reset gates the write path so an abandoned packet never reaches the FIFO
  assign w_xfer      = (r_state == XFER) && !wrst;
  assign w_sel_valid = bus.req_valid[r_gid];
  assign w_sel_last  = bus.req_last[r_gid];
  assign w_sel_data  = bus.req_data[r_gid*DW +: DW];
  assign w_accept    = w_xfer && w_sel_valid && !bus.wfull;
  assign w_release   = w_accept && (w_sel_last || (r_cnt == LAST_CNT));

  assign bus.winc      = w_accept;
  assign bus.wdata     = w_xfer ? w_sel_data : '0;
  assign bus.grant_vld = r_gvld;
  assign bus.grant_id  = r_gid;
  assign bus.pkt_err   = r_err;

  // Only the grant holder sees ready, and only while the FIFO has room
  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) bus.req_ready[r_gid] = !bus.wfull;
  end

  // Grant FSM with beat counting and forced release at MAX_BEATS
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= IDLE;
      r_rr    <= RR_RST;
      r_gid   <= '0;
      r_gvld  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((|w_pick_oh) && !bus.awfull && !bus.wfull) begin
            r_gid   <= w_pick_idx;
            r_gvld  <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_release) begin
            r_rr    <= r_gid;
            r_cnt   <= '0;
            r_gvld  <= 1'b0;
            r_state <= IDLE;
            if (!w_sel_last) r_err <= 1'b1;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef EBI_WARB_PERF_CNT_EN
  logic [NREQ*32-1:0] r_beat_cnt;
  logic [31:0]        r_stall_cnt;

  assign bus.beat_cnt  = r_beat_cnt;
  assign bus.stall_cnt = r_stall_cnt;

  // Wrapping beat counters per requester; saturating stall counter
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept)
        r_beat_cnt[r_gid*32 +: 32] <= r_beat_cnt[r_gid*32 +: 32] + 32'd1;
      if ((r_state == XFER) && w_sel_valid && bus.wfull && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
